// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter and its read-response tracker.
package dmem_arb_pkg;

  localparam int ARB_ADDR_WIDTH       = 32;
  localparam int ARB_DATA_WIDTH       = 32;
  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int STARVE_CNT_WIDTH     = 4;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_DMA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic                      we;
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [ARB_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_rsp_tracker.sv
// Two-stage {valid, owner} pipe that follows each granted read to the cycle its data
// appears on mem_rdata, and steers the read-valid strobe to the owning port.
module dmem_rsp_tracker
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic issue_read,
  input  logic issue_owner,
  output logic core_rvalid,
  output logic dma_rvalid
);

  logic   s1_valid_r;
  logic   s2_valid_r;
  owner_e s1_owner_r;
  owner_e s2_owner_r;

  // Advance read ownership in lockstep with the memory command and data stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s1_owner_r <= OWNER_CORE;
      s2_owner_r <= OWNER_CORE;
    end else begin
      s1_valid_r <= issue_read;
      s1_owner_r <= owner_e'(issue_owner);
      s2_valid_r <= s1_valid_r;
      s2_owner_r <= s1_owner_r;
    end
  end

  assign core_rvalid = s2_valid_r & (s2_owner_r == OWNER_CORE);
  assign dma_rvalid  = s2_valid_r & (s2_owner_r == OWNER_DMA);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core MEM stage and a DMA/debug master:
// core-priority arbitration with a starvation override, registered memory command.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_stall,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_r;
  logic                        core_win_s;
  logic                        dma_win_s;
  logic                        issue_read_s;

  // Core has priority unless DMA has been denied long enough to be forced through.
  always_comb begin
    core_win_s = 1'b0;
    dma_win_s  = 1'b0;
    if (reset) begin
      core_win_s = 1'b0;
      dma_win_s  = 1'b0;
    end else if (dma_req && (starve_cnt_r == STARVE_MAX)) begin
      dma_win_s = 1'b1;
    end else if (core_req) begin
      core_win_s = 1'b1;
    end else if (dma_req) begin
      dma_win_s = 1'b1;
    end else begin
      core_win_s = 1'b0;
      dma_win_s  = 1'b0;
    end
  end

  assign core_gnt   = core_win_s;
  assign dma_gnt    = dma_win_s;
  assign core_stall = core_req & ~core_win_s;

  // Count consecutive denied DMA cycles; any gap in the request restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= '0;
    end else if (!dma_req || dma_win_s) begin
      starve_cnt_r <= '0;
    end else if (starve_cnt_r != STARVE_MAX) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Register the winning command; address and write data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (core_win_s) begin
      mem_read  <= ~core_we;
      mem_write <= core_we;
      mem_addr  <= core_addr;
      mem_wdata <= core_wdata;
    end else if (dma_win_s) begin
      mem_read  <= ~dma_we;
      mem_write <= dma_we;
      mem_addr  <= dma_addr;
      mem_wdata <= dma_wdata;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  assign issue_read_s = (core_win_s & ~core_we) | (dma_win_s & ~dma_we);

  dmem_rsp_tracker u_rsp_tracker (
    .clk         (clk),
    .reset       (reset),
    .issue_read  (issue_read_s),
    .issue_owner (dma_win_s),
    .core_rvalid (core_rvalid),
    .dma_rvalid  (dma_rvalid)
  );

  assign core_rdata = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (`d_memory`) between the core's MEM stage and a DMA/debug master. Each cycle it grants at most one requester and registers that requester's command onto the memory port. It returns read data to the owning port with a fixed latency and raises a stall toward the pipeline's `combined_stall` logic whenever the core is denied. Core has priority; a starvation counter guarantees DMA forward progress.

## Interface
- `ADDR_WIDTH`, 32, address width of both ports and the memory.
- `DATA_WIDTH`, 32, data width.
- `STARVE_LIMIT`, 4, consecutive denied DMA cycles before DMA is forced to win; legal range 1–15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `core_req`  in  1  core access request; held until granted.
- `core_we`  in  1  1 = write, 0 = read.
- `core_addr`  in  ADDR_WIDTH  byte address.
- `core_wdata`  in  DATA_WIDTH  write data.
- `core_gnt`  out  1  combinational; request accepted this cycle.
- `core_stall`  out  1  `core_req & ~core_gnt`.
- `core_rvalid`  out  1  read data valid.
- `core_rdata`  out  DATA_WIDTH  read data.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`: same directions, widths and semantics for the DMA port. There is no DMA stall output.
- `mem_read`  out  1  registered memory read enable.
- `mem_write`  out  1  registered memory write enable.
- `mem_addr`  out  ADDR_WIDTH  registered address.
- `mem_wdata`  out  DATA_WIDTH  registered write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid the cycle after `mem_read` is high.

## Operation
- **Arbitration.** Arbitration is combinational from `core_req`, `dma_req` and `starve_cnt`.
  - If `starve_cnt == STARVE_LIMIT` and `dma_req` is high, DMA wins.
  - Otherwise the core wins if `core_req` is high.
  - Otherwise DMA wins if `dma_req` is high.
  - Otherwise nothing is granted.
- **Command register.** On a grant, the winner's `we`, `addr` and `wdata` are loaded into `mem_*` at the clock edge. `mem_read` is set to `~we` and `mem_write` to `we`. With no grant, `mem_read` and `mem_write` clear to 0, and `mem_addr`/`mem_wdata` hold their values.
- **Starvation counter.** `starve_cnt` is 4 bits.
  - Increments when `dma_req & ~dma_gnt`.
  - Clears when `dma_gnt` is high or `dma_req` is low.
  - Saturates at `STARVE_LIMIT`.
- **Response tracking.** A 2-stage shift register of {valid, owner} follows each read.
  - Stage 1 is loaded alongside the `mem_*` command.
  - Stage 2 is valid in the same cycle as `mem_rdata`.
  - `core_rvalid` = stage2.valid & owner==CORE; `dma_rvalid` likewise for DMA.
  - `core_rdata` and `dma_rdata` both pass `mem_rdata` through combinationally. Each is qualified only by its own rvalid.
  - Writes produce no rvalid.
- **Throughput.** Back-to-back grants are allowed every cycle, and reads from different owners may interleave.
- **Reset.** While `reset` is high at the edge:
  - `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` go to 0; `starve_cnt` goes to 0; both tracker stages are cleared.
  - `core_rvalid` and `dma_rvalid` read 0 in the cycle after reset is sampled.
  - Reads in flight when reset hits never return.
  - Grants are masked to 0 while `reset` is high.

## Timing
- **Cycle N:** `req` high with fields stable; `gnt` is high in N if the requester won.
- **Cycle N+1:** `mem_read`/`mem_write` high with the registered command.
- **Cycle N+2:** `mem_rdata` valid and the matching `*_rvalid` is high, giving a read latency of 2 cycles from grant.
- **Denied requests:** the requester must hold `req` and its fields stable until it sees `gnt`. While the core is denied, `core_stall` stays high.
- **Starvation bound:** with both requesters continuously requesting, DMA is granted in exactly 1 of every `STARVE_LIMIT+1` cycles.
- **Simultaneous events:** a DMA grant forced by starvation in cycle N stalls the core for exactly that cycle.

## Structure
- Package `dmem_arb_pkg` contains:
  - owner enum `OWNER_CORE = 1'b0`, `OWNER_DMA = 1'b1`;
  - a packed request struct {we, addr, wdata};
  - default `STARVE_LIMIT` constant.
- Sub-module `dmem_rsp_tracker` holds the 2-stage valid/owner shift register and decodes the per-port rvalid outputs. The arbiter, counter and command register stay in `dmem_arbiter`.

## Test plan
- **Core read after reset:** core read at 0x0000_0010 with memory returning 0xDEAD_BEEF → `core_gnt` in cycle 0, `mem_read` in cycle 1, `core_rvalid` with 0xDEAD_BEEF in cycle 2, `dma_rvalid` stays 0.
- **Core/DMA contention:** both request continuously with `STARVE_LIMIT=4` → grant sequence C,C,C,C,D repeating. `core_stall` is high only in the D cycles, and every DMA read returns on `dma_rvalid` only.
- **Interleaved reads:** core read to A in cycle 0, DMA read to B in cycle 1 → `core_rvalid` in cycle 2, `dma_rvalid` in cycle 3, each carrying its own data.
- **Write:** DMA write 0x1234_5678 to 0x40 → `mem_write=1`, `mem_addr=0x40`, `mem_wdata=0x1234_5678` in cycle 1. No rvalid on either port.
- **Reset mid-operation:** core read granted in cycle 0, `reset` high in cycle 1 → no `core_rvalid` in cycle 2, all `mem_*` outputs 0, and `starve_cnt` is 0 afterwards.
- **DMA request drop:** DMA request dropped after 3 denied cycles → counter clears. When it is reasserted, DMA needs 4 more denied cycles before it is forced to win.
